// File: rtl/robo_ctrl.sv
// Wall-following maze controller: samples the map sensors, then issues one move/turn/clear pulse per decision.
// Define ROBO_CTRL_STEP_LIMIT_EN to abort a run into FAIL once step_count reaches MAX_STEPS.
module robo_ctrl #(
    parameter int SETTLE_CYCLES = 2,
    parameter int MAX_STEPS     = 400
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        head_in,
    input  logic        left_in,
    input  logic        under_in,
    input  logic        barrier_in,
    output logic        avancar,
    output logic        girar,
    output logic        remover,
    output logic        busy,
    output logic        done,
    output logic        fail,
    output logic [15:0] step_count
);

    generate
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15 || MAX_STEPS < 1 || MAX_STEPS > 65535) begin : g_bad_params
            $error("robo_ctrl: parameter out of range");
        end
    endgenerate

    typedef enum logic [3:0] {
        IDLE, DECIDE, FWD, TURN_L, TURN_R, REMOVE, WAIT, DONE, FAIL
    } state_t;

    state_t     state;
    logic [3:0] wait_cnt;
    logic [1:0] turn_pend;   // girar pulses still owed by a left turn
    logic       turned_left;

`ifdef ROBO_CTRL_STEP_LIMIT_EN
    logic fail_q;
    assign fail = fail_q;
`else
    assign fail = 1'b0;
`endif

    // The settle window is the command cycle, the WAIT cycles and the DECIDE
    // cycle whose closing edge samples the sensors: SETTLE_CYCLES idle cycles
    // between a pulse and the next sample, one command every SETTLE_CYCLES+1.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            wait_cnt    <= 4'd0;
            turn_pend   <= 2'd0;
            turned_left <= 1'b0;
            step_count  <= 16'd0;
            avancar     <= 1'b0;
            girar       <= 1'b0;
            remover     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef ROBO_CTRL_STEP_LIMIT_EN
            fail_q      <= 1'b0;
`endif
        end else begin
            avancar <= 1'b0;
            girar   <= 1'b0;
            remover <= 1'b0;
            case (state)
                IDLE, DONE, FAIL: begin
                    if (start) begin
                        state       <= DECIDE;
                        step_count  <= 16'd0;
                        turned_left <= 1'b0;
                        turn_pend   <= 2'd0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
`ifdef ROBO_CTRL_STEP_LIMIT_EN
                        fail_q      <= 1'b0;
`endif
                    end
                end
                DECIDE: begin
                    if (turn_pend != 2'd0) begin
                        // mid left turn: finish the rotation before looking again
                        state     <= TURN_L;
                        girar     <= 1'b1;
                        turn_pend <= turn_pend - 2'd1;
                    end else if (under_in) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
`ifdef ROBO_CTRL_STEP_LIMIT_EN
                    else if (step_count == 16'(MAX_STEPS)) begin
                        state  <= FAIL;
                        busy   <= 1'b0;
                        fail_q <= 1'b1;
                    end
`endif
                    else if (barrier_in) begin
                        state   <= REMOVE;
                        remover <= 1'b1;
                    end else if (!left_in && !turned_left) begin
                        // three clockwise quarter turns make one left turn
                        state     <= TURN_L;
                        girar     <= 1'b1;
                        turn_pend <= 2'd2;
                    end else if (!head_in) begin
                        state       <= FWD;
                        avancar     <= 1'b1;
                        turned_left <= 1'b0;
                        if (step_count != 16'hFFFF)
                            step_count <= step_count + 16'd1;
                    end else begin
                        state <= TURN_R;
                        girar <= 1'b1;
                    end
                end
                FWD, TURN_L, TURN_R, REMOVE: begin
                    if (state == TURN_L && turn_pend == 2'd0)
                        turned_left <= 1'b1;
                    if (SETTLE_CYCLES > 1) begin
                        state    <= WAIT;
                        wait_cnt <= 4'(SETTLE_CYCLES - 2);
                    end else begin
                        state <= DECIDE;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0)
                        state <= DECIDE;
                    else
                        wait_cnt <= wait_cnt - 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
